// File: rtl/mulacc_simd_cfu_li2_pkg.sv
// Shared constants and types for the SIMD multiply-accumulate CFU.
package mulacc_pkg;

    // Architectural function ids seen on req_func_id
    localparam int FUNC_CLR  = 0;
    localparam int FUNC_UMAC = 1;
    localparam int FUNC_SMAC = 2;
    localparam int FUNC_READ = 3;

    // Error ids reported on resp_err_id
    localparam int ERR_NONE     = 0;
    localparam int ERR_BAD_FUNC = 1;

    // Widest accumulator select carried in the control struct (up to 256 accumulators)
    localparam int ACC_ID_MAX_W = 8;

    // Decoded operation; every undefined func id collapses to OP_BAD at accept
    typedef enum logic [2:0] {
        OP_CLR  = 3'd0,
        OP_UMAC = 3'd1,
        OP_SMAC = 3'd2,
        OP_READ = 3'd3,
        OP_BAD  = 3'd4
    } op_e;

    // Per-stage pipeline control
    typedef struct packed {
        logic                    valid;
        op_e                     func;
        logic [ACC_ID_MAX_W-1:0] acc_id;
    } ctrl_t;

    function automatic logic op_is_mac(input op_e op);
        return (op == OP_UMAC) || (op == OP_SMAC);
    endfunction

endpackage

// File: rtl/mulacc_simd_cfu_li2_simd_dot_mul.sv
// Element-wise SIMD multiplier: N_ELTS products of 2*ELT_W bits, registered.
// Operands are extended to the product width first (sign or zero), so the low
// 2*ELT_W bits of a plain multiply are the exact signed/unsigned product.
module simd_dot_mul #(
    parameter  int DATA_W = 32,
    parameter  int ELT_W  = 8,
    localparam int N_ELTS = DATA_W / ELT_W,
    localparam int PROD_W = 2 * ELT_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           sgn,
    input  logic [DATA_W-1:0]              a,
    input  logic [DATA_W-1:0]              b,
    output logic [N_ELTS-1:0][PROD_W-1:0]  prod
);

    logic [N_ELTS-1:0][PROD_W-1:0] prod_d;

    for (genvar e = 0; e < N_ELTS; e++) begin : g_elt
        logic [ELT_W-1:0]  ea, eb;
        logic [PROD_W-1:0] xa, xb;
        assign ea        = a[e*ELT_W +: ELT_W];
        assign eb        = b[e*ELT_W +: ELT_W];
        assign xa        = sgn ? PROD_W'($signed(ea)) : PROD_W'(ea);
        assign xb        = sgn ? PROD_W'($signed(eb)) : PROD_W'(eb);
        assign prod_d[e] = xa * xb;
    end

    // Capture products when the pipeline advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     prod <= '0;
        else if (en) prod <= prod_d;
    end

endmodule

// File: rtl/mulacc_simd_cfu_li2.sv
// SIMD multiply-accumulate CFU with N_ACC accumulators and whole-pipe stall.
// Stages: accept (products) -> optional delay stages -> update (acc write)
// -> output register. Only the update stage touches the accumulators and it
// retires one op per cycle in order, so back-to-back ops on the same
// accumulator always see the previous result without a bubble.
module mulacc_simd_cfu_li2
    import mulacc_pkg::*;
#(
    parameter  int CFU_FUNC_ID_W    = 3,
    parameter  int CFU_REQ_DATA_W   = 32,
    parameter  int CFU_REQ_ELT_W    = 8,
    parameter  int CFU_RESP_DATA_W  = 32,
    parameter  int CFU_ERR_ID_W     = 32,
    parameter  int CFU_RESP_LATENCY = 3,
    parameter  int N_ACC            = 4,
    localparam int ACC_ID_W         = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [CFU_FUNC_ID_W-1:0]   req_func_id,
    input  logic [ACC_ID_W-1:0]        req_acc_id,
    input  logic [CFU_REQ_DATA_W-1:0]  req_data0,
    input  logic [CFU_REQ_DATA_W-1:0]  req_data1,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [CFU_RESP_DATA_W-1:0] resp_data,
    output logic                       resp_err,
    output logic [CFU_ERR_ID_W-1:0]    resp_err_id
);

    localparam int N_ELTS = CFU_REQ_DATA_W / CFU_REQ_ELT_W;
    localparam int PROD_W = 2 * CFU_REQ_ELT_W;
    localparam int MID    = CFU_RESP_LATENCY - 3;

    typedef logic [N_ELTS-1:0][PROD_W-1:0] prod_t;

    // Whole pipe moves only when the output slot is free or being drained
    logic advance;
    assign advance   = !resp_valid || resp_ready;
    assign req_ready = advance;

    // Decode the raw func id; anything outside the defined set is an error op
    op_e req_op;
    always_comb begin
        req_op = OP_BAD;
        case (req_func_id)
            CFU_FUNC_ID_W'(FUNC_CLR):  req_op = OP_CLR;
            CFU_FUNC_ID_W'(FUNC_UMAC): req_op = OP_UMAC;
            CFU_FUNC_ID_W'(FUNC_SMAC): req_op = OP_SMAC;
            CFU_FUNC_ID_W'(FUNC_READ): req_op = OP_READ;
            default:                   req_op = OP_BAD;
        endcase
    end

    // Stage 0: capture control alongside the registered products
    ctrl_t ctl_s0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ctl_s0 <= '0;
        else if (advance) ctl_s0 <= '{valid:  req_valid,
                                      func:   req_op,
                                      acc_id: ACC_ID_MAX_W'(req_acc_id)};
    end

    prod_t mul_prod;
    simd_dot_mul #(
        .DATA_W (CFU_REQ_DATA_W),
        .ELT_W  (CFU_REQ_ELT_W)
    ) u_mul (
        .clk  (clk),
        .rst  (rst),
        .en   (advance),
        .sgn  (req_op == OP_SMAC),
        .a    (req_data0),
        .b    (req_data1),
        .prod (mul_prod)
    );

    // Delay stages that pad the pipe out to the configured latency
    ctrl_t ctl_tail;
    prod_t prod_tail;
    if (MID == 0) begin : g_nomid
        assign ctl_tail  = ctl_s0;
        assign prod_tail = mul_prod;
    end else begin : g_mid
        ctrl_t ctl_mid  [MID];
        prod_t prod_mid [MID];

        // Shift control and products one stage per advance
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < MID; s++) begin
                    ctl_mid[s]  <= '0;
                    prod_mid[s] <= '0;
                end
            end else if (advance) begin
                ctl_mid[0]  <= ctl_s0;
                prod_mid[0] <= mul_prod;
                for (int s = 1; s < MID; s++) begin
                    ctl_mid[s]  <= ctl_mid[s-1];
                    prod_mid[s] <= prod_mid[s-1];
                end
            end
        end

        assign ctl_tail  = ctl_mid[MID-1];
        assign prod_tail = prod_mid[MID-1];
    end

    // Upper select bits are only there to size the shared struct
    logic unused_acc_id;
    assign unused_acc_id = ^ctl_tail.acc_id;

    logic [ACC_ID_W-1:0] upd_idx;
    assign upd_idx = (N_ACC == 1) ? '0 : ACC_ID_W'(ctl_tail.acc_id);

    // Reduce the element products to one accumulator-width addend
    logic [CFU_RESP_DATA_W-1:0] dot_sum;
    always_comb begin
        dot_sum = '0;
        for (int e = 0; e < N_ELTS; e++) begin
            if (ctl_tail.func == OP_SMAC)
                dot_sum = dot_sum + CFU_RESP_DATA_W'($signed(prod_tail[e]));
            else
                dot_sum = dot_sum + CFU_RESP_DATA_W'(prod_tail[e]);
        end
    end

    logic [N_ACC-1:0][CFU_RESP_DATA_W-1:0] acc;
    logic [CFU_RESP_DATA_W-1:0]            acc_cur, acc_nxt;
    assign acc_cur = acc[upd_idx];

    // Post-op value of the selected accumulator
    always_comb begin
        acc_nxt = acc_cur;
        if (ctl_tail.func == OP_CLR)     acc_nxt = '0;
        else if (op_is_mac(ctl_tail.func)) acc_nxt = acc_cur + dot_sum;
    end

    // Update stage: write the accumulator and carry its new value forward
    logic                       upd_valid, upd_bad;
    logic [CFU_RESP_DATA_W-1:0] upd_val;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            upd_valid <= 1'b0;
            upd_bad   <= 1'b0;
            upd_val   <= '0;
        end else if (advance) begin
            upd_valid <= ctl_tail.valid;
            upd_bad   <= ctl_tail.func == OP_BAD;
            upd_val   <= acc_nxt;
            if (ctl_tail.valid) acc[upd_idx] <= acc_nxt;
        end
    end

    // Output stage: load a response slot; held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            resp_err_id <= '0;
        end else if (advance) begin
            resp_valid <= upd_valid;
            if (upd_valid) begin
                resp_data   <= upd_bad ? '0 : upd_val;
                resp_err    <= upd_bad;
                resp_err_id <= upd_bad ? CFU_ERR_ID_W'(ERR_BAD_FUNC)
                                       : CFU_ERR_ID_W'(ERR_NONE);
            end
        end
    end

endmodule

// File: tb/tb_mulacc_simd_cfu_li2.sv
// Bench for mulacc_simd_cfu_li2: table vectors, directed sequences and a
// randomized stalled stream, all scored against an in-order dot-product model.
module tb_mulacc_simd_cfu_li2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_func_id;
    logic [1:0]  req_acc_id;
    logic [31:0] req_data0, req_data1;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_data, resp_err_id;

    always #5 clk = ~clk;

    mulacc_simd_cfu_li2 dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_func_id (req_func_id),
        .req_acc_id  (req_acc_id),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .resp_err_id (resp_err_id)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [31:0] err_id;
    } exp_t;

    typedef struct {
        logic [2:0]  f;
        logic [1:0]  id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] model_acc [4];
    int          checks = 0;
    int          errors = 0;
    logic        got_resp = 1'b0;
    logic [31:0] last_data = '0;
    logic        last_err = 1'b0;
    logic        req_fired = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_err = 1'b0;
    vec_t        tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Dot product of four byte lanes, signed or unsigned, mod 2^32
    function automatic logic [31:0] dot4(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int s, xa, xb;
        logic [7:0] ea, eb;
        s = 0;
        for (int e = 0; e < 4; e++) begin
            ea = a[8*e +: 8];
            eb = b[8*e +: 8];
            xa = sgn ? {{24{ea[7]}}, ea} : {24'b0, ea};
            xb = sgn ? {{24{eb[7]}}, eb} : {24'b0, eb};
            s  = s + xa * xb;
        end
        return 32'(s);
    endfunction

    task automatic model_issue();
        exp_t x;
        x.data = '0; x.err = 1'b0; x.err_id = '0;
        case (req_func_id)
            3'd0: model_acc[req_acc_id] = '0;
            3'd1: model_acc[req_acc_id] = model_acc[req_acc_id] + dot4(1'b0, req_data0, req_data1);
            3'd2: model_acc[req_acc_id] = model_acc[req_acc_id] + dot4(1'b1, req_data0, req_data1);
            default: ;
        endcase
        if (req_func_id <= 3'd3) x.data = model_acc[req_acc_id];
        else begin x.err = 1'b1; x.err_id = 32'd1; end
        exp_q.push_back(x);
    endtask

    task automatic check_resp();
        exp_t x;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got data %h with nothing outstanding", resp_data);
        end else begin
            x = exp_q.pop_front();
            chk("resp_data", resp_data, x.data);
            chk("resp_err", 32'(resp_err), 32'(x.err));
            chk("resp_err_id", resp_err_id, x.err_id);
        end
        got_resp  = 1'b1;
        last_data = resp_data;
        last_err  = resp_err;
    endtask

    // One clock: observe at the falling edge, return just after the rising edge
    task automatic tick();
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(!resp_valid || resp_ready));
        if (prev_stall) begin
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_data", resp_data, held_data);
            chk("hold_err", 32'(resp_err), 32'(held_err));
        end
        prev_stall = resp_valid && !resp_ready;
        held_data  = resp_data;
        held_err   = resp_err;
        req_fired  = req_valid && req_ready;
        if (resp_valid && resp_ready) check_resp();
        if (req_fired) model_issue();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [1:0] id, input logic [31:0] a, input logic [31:0] b);
        logic done;
        done = 1'b0;
        req_valid = 1'b1; req_func_id = f; req_acc_id = id; req_data0 = a; req_data1 = b;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            done = req_fired;
        end
        if (!done) fail_now("issue_accept");
        req_valid = 1'b0;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_one(input string name, input logic [2:0] f, input logic [1:0] id,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_d, input logic exp_e);
        got_resp = 1'b0;
        issue(f, id, a, b);
        for (int i = 0; i < 50 && !got_resp; i++) tick();
        if (!got_resp) fail_now(name);
        else begin
            chk(name, last_data, exp_d);
            chk({name, "_err"}, 32'(last_err), 32'(exp_e));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) model_acc[k] = '0;
        tbl[0]  = '{3'd0, 2'd1, 32'h0,        32'h0,        32'h0,        1'b0};
        tbl[1]  = '{3'd2, 2'd1, 32'hFFFFFFFF, 32'h02020202, 32'hFFFFFFF8, 1'b0};
        tbl[2]  = '{3'd0, 2'd2, 32'h0,        32'h0,        32'h0,        1'b0};
        tbl[3]  = '{3'd1, 2'd2, 32'hFFFFFFFF, 32'h02020202, 32'd2040,     1'b0};
        tbl[4]  = '{3'd5, 2'd2, 32'h12345678, 32'h9ABCDEF0, 32'h0,        1'b1};
        tbl[5]  = '{3'd3, 2'd2, 32'h0,        32'h0,        32'd2040,     1'b0};
        tbl[6]  = '{3'd3, 2'd1, 32'h0,        32'h0,        32'hFFFFFFF8, 1'b0};
        tbl[7]  = '{3'd2, 2'd1, 32'h80808080, 32'h80808080, 32'h0000FFF8, 1'b0};
        tbl[8]  = '{3'd7, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[9]  = '{3'd0, 2'd3, 32'h0,        32'h0,        32'h0,        1'b0};
        tbl[10] = '{3'd1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0003F804, 1'b0};
        tbl[11] = '{3'd2, 2'd3, 32'h7F7F7F7F, 32'h80808080, 32'h0002FA04, 1'b0};
        tbl[12] = '{3'd4, 2'd3, 32'h11111111, 32'h22222222, 32'h0,        1'b1};
        tbl[13] = '{3'd3, 2'd3, 32'h0,        32'h0,        32'h0002FA04, 1'b0};
        tbl[14] = '{3'd3, 2'd0, 32'h0,        32'h0,        32'd20200,    1'b0};

        rst = 1'b1; req_valid = 1'b0; req_func_id = '0; req_acc_id = '0;
        req_data0 = '0; req_data1 = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_err_id", resp_err_id, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Cumulative dot product over 100 back-to-back requests
        issue(3'd0, 2'd0, 32'h0, 32'h0);
        for (int n = 1; n <= 100; n++) issue(3'd1, 2'd0, 32'h01010101, {4{8'(n)}});
        drain();
        chk("dot_100", last_data, 32'd20200);

        // Table vectors: signed/unsigned, wrap-free extremes, undefined ids
        for (int i = 0; i < 15; i++)
            apply_one($sformatf("tbl%0d", i), tbl[i].f, tbl[i].id, tbl[i].a, tbl[i].b,
                      tbl[i].exp_data, tbl[i].exp_err);

        // Interleaved accumulators at II=1
        for (int k = 0; k < 4; k++) issue(3'd0, 2'(k), 32'h0, 32'h0);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 4; k++) issue(3'd1, 2'(k), 32'h01010101, {4{8'(k + 1)}});
        drain();
        for (int k = 0; k < 4; k++)
            apply_one($sformatf("inter_acc%0d", k), 3'd3, 2'(k), 32'h0, 32'h0, 32'(12 * (k + 1)), 1'b0);

        // Randomized stream with consumer backpressure and a forced 5-cycle stall
        req_valid = 1'b0; req_fired = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!req_valid || req_fired) begin
                req_valid   = ($urandom_range(0, 3) != 0);
                req_func_id = 3'($urandom_range(0, 9) % 8);
                req_acc_id  = 2'($urandom_range(0, 3));
                req_data0   = $urandom;
                req_data1   = $urandom;
            end
            resp_ready = (c >= 100 && c < 105) ? 1'b0 : ($urandom_range(0, 3) != 0);
            tick();
        end
        resp_ready = 1'b1;
        drain();

        // Asynchronous reset with two ops in flight
        req_valid = 1'b1; req_func_id = 3'd1; req_acc_id = 2'd0;
        req_data0 = 32'h01010101; req_data1 = 32'h03030303;
        tick();
        chk("inflight_acc1", 32'(req_fired), 32'd1);
        tick();
        chk("inflight_acc2", 32'(req_fired), 32'd1);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(resp_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(resp_valid), 32'd0);
        chk("async_rst_data", resp_data, 32'd0);
        exp_q.delete();
        for (int k = 0; k < 4; k++) model_acc[k] = '0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        for (int k = 0; k < 4; k++)
            apply_one($sformatf("post_rst_acc%0d", k), 3'd3, 2'(k), 32'h0, 32'h0, 32'h0, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
